mem_access: RTL and testbench

Memory-access stage directly downstream of the EX stage. Takes EX results (write-enable, destination register, ALU value) plus load/store fields, passes non-memory results through one register stage, and runs load/store operations over a req/ack data bus with a small state machine. Stalls the upstream pipe via `ex_ready`/`stall_req` while a bus access is outstanding, then presents the final write-back triple to WB.

---
 rtl/mem_access_pkg.sv | 48 ++++
 rtl/mem_lane_align.sv | 65 ++++++
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// +------------------------------------------------------------------+
// | mem_access_pkg : shared widths, memop codes and FSM states        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mem_access_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0] zeroword = '0;

  localparam logic [2:0] MEMOP_NONE = 3'b000;
  localparam logic [2:0] MEMOP_LB   = 3'b001;
  localparam logic [2:0] MEMOP_LBU  = 3'b010;
  localparam logic [2:0] MEMOP_LW   = 3'b011;
  localparam logic [2:0] MEMOP_SB   = 3'b101;
  localparam logic [2:0] MEMOP_SW   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Collapse unused encodings onto NONE so downstream decode stays simple.
  function automatic logic [2:0] memop_norm(input logic [2:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_LW, MEMOP_SB, MEMOP_SW: return op;
      default:                                           return MEMOP_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LW);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEMOP_SB) || (op == MEMOP_SW);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == MEMOP_LW) || (op == MEMOP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +------------------------------------------------------------------+
// | mem_lane_align : big-endian byte-lane select, store replication   |
// | and load extraction/extension. Rev 1.0                            |
// +------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]        memop_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [RegBus-1:0] sdata_i,
  input  logic [RegBus-1:0] rdata_i,
  output logic [3:0]        sel_o,
  output logic [RegBus-1:0] wdata_o,
  output logic [RegBus-1:0] ldata_o
);

  logic [3:0] w_byte_sel;
  logic [7:0] w_lane;

  // Byte 0 of a word sits in bits [31:24].
  always_comb begin
    w_byte_sel = 4'b0000;
    w_lane     = 8'h00;
    case (addr_lo_i)
      2'd0: begin w_byte_sel = 4'b1000; w_lane = rdata_i[31:24]; end
      2'd1: begin w_byte_sel = 4'b0100; w_lane = rdata_i[23:16]; end
      2'd2: begin w_byte_sel = 4'b0010; w_lane = rdata_i[15:8];  end
      default: begin w_byte_sel = 4'b0001; w_lane = rdata_i[7:0]; end
    endcase
  end

  always_comb begin
    sel_o   = 4'b0000;
    wdata_o = zeroword;
    ldata_o = zeroword;
    case (memop_i)
      MEMOP_LB: begin
        sel_o   = w_byte_sel;
        ldata_o = {{24{w_lane[7]}}, w_lane};
      end
      MEMOP_LBU: begin
        sel_o   = w_byte_sel;
        ldata_o = {24'h000000, w_lane};
      end
      MEMOP_LW: begin
        sel_o   = 4'b1111;
        ldata_o = rdata_i;
      end
      MEMOP_SB: begin
        sel_o   = w_byte_sel;
        wdata_o = {4{sdata_i[7:0]}};
      end
      MEMOP_SW: begin
        sel_o   = 4'b1111;
        wdata_o = sdata_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// +------------------------------------------------------------------+
// | mem_access : MEM stage with req/ack data-bus FSM and WB register. |
// | Option MEM_ALIGN_CHECK_EN traps misaligned LW/SW. Rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_we,
  input  logic [RegAddrBus-1:0] ex_waddr,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [2:0]            ex_memop,
  input  logic [ADDR_W-1:0]     ex_memaddr,
  input  logic [DATA_W-1:0]     ex_sdata,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [ADDR_W-1:0]     dbus_addr,
  output logic [3:0]            dbus_sel,
  output logic [DATA_W-1:0]     dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [DATA_W-1:0]     dbus_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [RegAddrBus-1:0] wb_waddr,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic                  stall_req,
  output logic                  exc_misalign
);

  state_e                state_q, state_d;
  logic [2:0]            memop_q, memop_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  we_q, we_d;
  logic [RegAddrBus-1:0] waddr_q, waddr_d;
  logic                  dbus_req_q, dbus_req_d;
  logic                  dbus_we_q, dbus_we_d;
  logic [ADDR_W-1:0]     dbus_addr_q, dbus_addr_d;
  logic [3:0]            dbus_sel_q, dbus_sel_d;
  logic [DATA_W-1:0]     dbus_wdata_q, dbus_wdata_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_we_q, wb_we_d;
  logic [RegAddrBus-1:0] wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0]     wb_wdata_q, wb_wdata_d;

  logic                  w_accept;
  logic                  w_misalign;
  logic [2:0]            w_op;
  logic [2:0]            w_la_op;
  logic [1:0]            w_la_addr;
  logic [3:0]            w_sel;
  logic [DATA_W-1:0]     w_st_wdata;
  logic [DATA_W-1:0]     w_ldata;

  assign w_op     = memop_norm(ex_memop);
  assign w_accept = ex_valid && (state_q == ST_IDLE);

  // One aligner serves both issue (live EX fields) and completion (latched fields).
  assign w_la_op   = (state_q == ST_REQ) ? memop_q   : w_op;
  assign w_la_addr = (state_q == ST_REQ) ? addr_lo_q : ex_memaddr[1:0];

  mem_lane_align u_lane (
    .memop_i   (w_la_op),
    .addr_lo_i (w_la_addr),
    .sdata_i   (ex_sdata),
    .rdata_i   (dbus_rdata),
    .sel_o     (w_sel),
    .wdata_o   (w_st_wdata),
    .ldata_o   (w_ldata)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic exc_q;

  assign w_misalign = is_word(w_op) && (ex_memaddr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) exc_q <= 1'b0;
    else      exc_q <= w_accept && w_misalign;
  end

  assign exc_misalign = exc_q;
`else
  assign w_misalign   = 1'b0;
  assign exc_misalign = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    memop_d      = memop_q;
    addr_lo_d    = addr_lo_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_sel_d   = dbus_sel_q;
    dbus_wdata_d = dbus_wdata_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_waddr_d   = '0;
    wb_wdata_d   = zeroword;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if ((is_load(w_op) || is_store(w_op)) && !w_misalign) begin
            state_d      = ST_REQ;
            memop_d      = w_op;
            addr_lo_d    = ex_memaddr[1:0];
            we_d         = ex_we;
            waddr_d      = ex_waddr;
            dbus_req_d   = 1'b1;
            dbus_we_d    = is_store(w_op);
            dbus_addr_d  = {ex_memaddr[ADDR_W-1:2], 2'b00};
            dbus_sel_d   = w_sel;
            dbus_wdata_d = w_st_wdata;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = ex_we && !w_misalign;
            wb_waddr_d = ex_waddr;
            wb_wdata_d = w_misalign ? zeroword : ex_wdata;
          end
        end
      end

      ST_REQ: begin
        if (dbus_ack) begin
          state_d      = ST_IDLE;
          dbus_req_d   = 1'b0;
          dbus_we_d    = 1'b0;
          dbus_addr_d  = '0;
          dbus_sel_d   = 4'b0000;
          dbus_wdata_d = zeroword;
          wb_valid_d   = 1'b1;
          wb_we_d      = is_load(memop_q) && we_q;
          wb_waddr_d   = waddr_q;
          wb_wdata_d   = is_load(memop_q) ? w_ldata : zeroword;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      memop_q      <= MEMOP_NONE;
      addr_lo_q    <= 2'b00;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_sel_q   <= 4'b0000;
      dbus_wdata_q <= zeroword;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= zeroword;
    end else begin
      state_q      <= state_d;
      memop_q      <= memop_d;
      addr_lo_q    <= addr_lo_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_sel_q   <= dbus_sel_d;
      dbus_wdata_q <= dbus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
    end
  end

  assign ex_ready   = (state_q == ST_IDLE);
  assign stall_req  = (state_q != ST_IDLE);
  assign dbus_req   = dbus_req_q;
  assign dbus_we    = dbus_we_q;
  assign dbus_addr  = dbus_addr_q;
  assign dbus_sel   = dbus_sel_q;
  assign dbus_wdata = dbus_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_waddr   = wb_waddr_q;
  assign wb_wdata   = wb_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// +------------------------------------------------------------------+
// | tb_mem_access : directed bench with write-back scoreboard.        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_memaddr, ex_sdata;
  logic [2:0]  ex_memop;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic        wb_valid, wb_we, stall_req, exc_misalign;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_we        (ex_we),
    .ex_waddr     (ex_waddr),
    .ex_wdata     (ex_wdata),
    .ex_memop     (ex_memop),
    .ex_memaddr   (ex_memaddr),
    .ex_sdata     (ex_sdata),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_sel     (dbus_sel),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_rdata   (dbus_rdata),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .stall_req    (stall_req),
    .exc_misalign (exc_misalign)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] sd);
    ex_valid   = 1'b1;
    ex_memop   = op;
    ex_memaddr = addr;
    ex_we      = we;
    ex_waddr   = wa;
    ex_wdata   = wd;
    ex_sdata   = sd;
  endtask

  // Every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wb_t e;
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(wb_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_triple", 64'({wb_we, wb_waddr, wb_wdata}), 64'(e));
      end
    end
  end

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
    ex_memop = 3'b000; ex_memaddr = '0; ex_sdata = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    step(); step();
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_dbus_req", 64'(dbus_req), 64'd0);
    check("rst_wb", 64'({wb_valid, wb_we, wb_waddr, wb_wdata}), 64'd0);
    check("rst_dbus", 64'({dbus_we, dbus_sel, dbus_addr}), 64'd0);
    check("rst_exc", 64'(exc_misalign), 64'd0);
    rst = 1'b1;
    step();

    // NONE op: one-cycle pass-through
    issue(3'b000, 32'h0, 1'b1, 5'd3, 32'h0000F0F0, 32'h0);
    exp_q.push_back('{we: 1'b1, waddr: 5'd3, wdata: 32'h0000F0F0});
    step(); ex_valid = 1'b0;
    check("none_wbv", 64'(wb_valid), 64'd1);
    check("none_req", 64'(dbus_req), 64'd0);
    step();
    check("none_wbv_drop", 64'(wb_valid), 64'd0);

    // LB at 0x102, ack in third REQ cycle
    issue(3'b001, 32'h102, 1'b1, 5'd5, 32'hAAAA5555, 32'h0);
    exp_q.push_back('{we: 1'b1, waddr: 5'd5, wdata: 32'hFFFFFF83});
    step(); ex_valid = 1'b0;
    check("lb_req", 64'(dbus_req), 64'd1);
    check("lb_addr", 64'(dbus_addr), 64'h100);
    check("lb_sel", 64'(dbus_sel), 64'b0010);
    check("lb_we", 64'(dbus_we), 64'd0);
    check("lb_wbv0", 64'(wb_valid), 64'd0);
    check("lb_ready1", 64'({ex_ready, stall_req}), 64'b01);
    step();
    check("lb_ready2", 64'(ex_ready), 64'd0);
    step();
    check("lb_ready3", 64'(ex_ready), 64'd0);
    check("lb_hold", 64'({dbus_req, dbus_sel, dbus_addr}), {27'd0, 1'b1, 4'b0010, 32'h100});
    dbus_ack = 1'b1; dbus_rdata = 32'h11228344;
    step(); dbus_ack = 1'b0;
    check("lb_wbv", 64'(wb_valid), 64'd1);
    check("lb_req_drop", 64'(dbus_req), 64'd0);
    check("lb_ready_back", 64'(ex_ready), 64'd1);

    // LBU at 0x102, ack in first REQ cycle
    issue(3'b010, 32'h102, 1'b1, 5'd6, 32'h0, 32'h0);
    exp_q.push_back('{we: 1'b1, waddr: 5'd6, wdata: 32'h00000083});
    step(); ex_valid = 1'b0;
    check("lbu_sel", 64'(dbus_sel), 64'b0010);
    dbus_ack = 1'b1; dbus_rdata = 32'h11228344;
    step(); dbus_ack = 1'b0;

    // SW at 0x200, ack in first REQ cycle
    issue(3'b111, 32'h200, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF);
    exp_q.push_back('{we: 1'b0, waddr: 5'd7, wdata: 32'h0});
    step(); ex_valid = 1'b0;
    check("sw_bus", 64'({dbus_req, dbus_we, dbus_sel, dbus_addr}), {26'd0, 1'b1, 1'b1, 4'b1111, 32'h200});
    check("sw_wdata", 64'(dbus_wdata), 64'hDEADBEEF);
    dbus_ack = 1'b1; dbus_rdata = 32'h12345678;
    step(); dbus_ack = 1'b0;
    check("sw_wb_we", 64'(wb_we), 64'd0);

    // SB at 0x203: last lane, data replicated
    issue(3'b101, 32'h203, 1'b0, 5'd8, 32'h0, 32'h123456A5);
    exp_q.push_back('{we: 1'b0, waddr: 5'd8, wdata: 32'h0});
    step(); ex_valid = 1'b0;
    check("sb_sel", 64'(dbus_sel), 64'b0001);
    check("sb_addr", 64'(dbus_addr), 64'h200);
    check("sb_wdata", 64'(dbus_wdata), 64'hA5A5A5A5);
    dbus_ack = 1'b1;
    step(); dbus_ack = 1'b0;

    // Ack while idle is ignored
    dbus_ack = 1'b1;
    step(); dbus_ack = 1'b0;
    check("idle_ack_req", 64'(dbus_req), 64'd0);
    step();
    check("idle_ack_wbv", 64'(wb_valid), 64'd0);

    // LW then a held ALU op
    issue(3'b011, 32'h300, 1'b1, 5'd9, 32'h0, 32'h0);
    exp_q.push_back('{we: 1'b1, waddr: 5'd9, wdata: 32'hCAFEBABE});
    step();
    issue(3'b000, 32'h0, 1'b1, 5'd10, 32'h00001234, 32'h0);
    exp_q.push_back('{we: 1'b1, waddr: 5'd10, wdata: 32'h00001234});
    check("b2b_stall", 64'(ex_ready), 64'd0);
    step();
    check("b2b_not_taken", 64'({ex_ready, wb_valid}), 64'b00);
    dbus_ack = 1'b1; dbus_rdata = 32'hCAFEBABE;
    step(); dbus_ack = 1'b0;
    check("b2b_lw_wb", 64'({wb_valid, wb_waddr}), {58'd0, 1'b1, 5'd9});
    check("b2b_ready", 64'(ex_ready), 64'd1);
    step(); ex_valid = 1'b0;
    check("b2b_alu_wb", 64'({wb_valid, wb_waddr}), {58'd0, 1'b1, 5'd10});
    step();
    check("b2b_done", 64'(wb_valid), 64'd0);

    // Misaligned LW
`ifdef MEM_ALIGN_CHECK_EN
    issue(3'b011, 32'h101, 1'b1, 5'd12, 32'h0, 32'h0);
    exp_q.push_back('{we: 1'b0, waddr: 5'd12, wdata: 32'h0});
    step(); ex_valid = 1'b0;
    check("mis_req", 64'(dbus_req), 64'd0);
    check("mis_exc", 64'(exc_misalign), 64'd1);
    check("mis_wb", 64'({wb_valid, wb_we}), 64'b10);
    step();
    check("mis_exc_drop", 64'(exc_misalign), 64'd0);
`else
    issue(3'b011, 32'h101, 1'b1, 5'd12, 32'h0, 32'h0);
    exp_q.push_back('{we: 1'b1, waddr: 5'd12, wdata: 32'h55667788});
    step(); ex_valid = 1'b0;
    check("mis_bus", 64'({dbus_req, dbus_sel, dbus_addr}), {27'd0, 1'b1, 4'b1111, 32'h100});
    dbus_ack = 1'b1; dbus_rdata = 32'h55667788;
    step(); dbus_ack = 1'b0;
    check("mis_exc", 64'(exc_misalign), 64'd0);
`endif

    // Reset during REQ, late ack ignored
    issue(3'b011, 32'h400, 1'b1, 5'd11, 32'h0, 32'h0);
    step(); ex_valid = 1'b0;
    check("rr_req", 64'(dbus_req), 64'd1);
    rst = 1'b0;
    step();
    check("rr_req_clr", 64'({dbus_req, ex_ready, wb_valid}), 64'b010);
    rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h99999999;
    step(); dbus_ack = 1'b0;
    check("rr_ack_ign", 64'({dbus_req, wb_valid, ex_ready}), 64'b001);
    step(); step();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
